// File: rtl/axil_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register file.
package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         BYTES       = 4;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_t;

    // Nonzero bits above the register index mark an out-of-range address.
    function automatic logic addr_oor(input logic [63:0] addr, input int idx_w);
        return (addr >> (idx_w + 2)) != 64'd0;
    endfunction

endpackage

// File: rtl/axil_regfile_wr_ch.sv
// Write channel: AW/W latching FSM producing a one-cycle commit strobe.
// AXIL_REGFILE_SLVERR_EN: drop out-of-range writes and answer SLVERR.
module axil_regfile_wr_ch
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [BYTES-1:0]        s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic                    commit_o,
    output logic                    commit_drop_o,
    output logic [IDX_W-1:0]        commit_idx_o,
    output logic [DATA_WIDTH-1:0]   commit_data_o,
    output logic [BYTES-1:0]        commit_strb_o
);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, oor;
    logic [ADDR_WIDTH-1:0] commit_addr;

    // Readies are held low during reset even though the state is already idle.
    assign s_awready = ~areset & (state_q == W_IDLE || state_q == W_HAVE_D);
    assign s_wready  = ~areset & (state_q == W_IDLE || state_q == W_HAVE_A);
    assign s_bvalid  = (state_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign aw_hs     = s_awvalid & s_awready;
    assign w_hs      = s_wvalid & s_wready;

    assign commit_addr   = (state_q == W_HAVE_A) ? awaddr_q : s_awaddr;
    assign commit_data_o = (state_q == W_HAVE_D) ? wdata_q  : s_wdata;
    assign commit_strb_o = (state_q == W_HAVE_D) ? wstrb_q  : s_wstrb;
    assign commit_idx_o  = commit_addr[IDX_W+1:2];
    assign oor           = addr_oor(64'(commit_addr), IDX_W);

`ifdef AXIL_REGFILE_SLVERR_EN
    assign commit_drop_o = oor;
`else
    logic unused_oor;
    assign unused_oor    = oor;
    assign commit_drop_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        commit_o = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_o = 1'b1;
                    state_d  = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d = s_awaddr;
                    state_d  = W_HAVE_A;
                end else if (w_hs) begin
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                    state_d  = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs) begin
                commit_o = 1'b1;
                state_d  = W_RESP;
            end
            W_HAVE_D: if (aw_hs) begin
                commit_o = 1'b1;
                state_d  = W_RESP;
            end
            W_RESP: if (s_bready) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
        if (commit_o) bresp_d = commit_drop_o ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
        end
    end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite register file: flat register outputs, per-register write pulses.
// AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of aliasing.
module axil_slave_regfile
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [ADDR_WIDTH-1:0]            s_awaddr,
    input  logic                             s_awvalid,
    output logic                             s_awready,
    input  logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [BYTES-1:0]                 s_wstrb,
    input  logic                             s_wvalid,
    output logic                             s_wready,
    output logic [1:0]                       s_bresp,
    output logic                             s_bvalid,
    input  logic                             s_bready,
    input  logic [ADDR_WIDTH-1:0]            s_araddr,
    input  logic                             s_arvalid,
    output logic                             s_arready,
    output logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rvalid,
    input  logic                             s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o,
    output logic [NUM_REGS-1:0]              wr_pulse_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 pulse_q, pulse_d;
    rd_state_t                           rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
    logic [1:0]                          rresp_q, rresp_d;

    logic                  commit, commit_drop;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [BYTES-1:0]      commit_strb;
    logic                  ar_hs, ar_oor;
    logic [IDX_W-1:0]      ar_idx;

    axil_regfile_wr_ch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ch (
        .aclk          (aclk),
        .areset        (areset),
        .s_awaddr      (s_awaddr),
        .s_awvalid     (s_awvalid),
        .s_awready     (s_awready),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_wvalid      (s_wvalid),
        .s_wready      (s_wready),
        .s_bresp       (s_bresp),
        .s_bvalid      (s_bvalid),
        .s_bready      (s_bready),
        .commit_o      (commit),
        .commit_drop_o (commit_drop),
        .commit_idx_o  (commit_idx),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb)
    );

    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;
    assign s_arready  = ~areset & (rd_state_q == R_IDLE);
    assign s_rvalid   = (rd_state_q == R_DATA);
    assign s_rdata    = rdata_q;
    assign s_rresp    = rresp_q;
    assign ar_hs      = s_arvalid & s_arready;
    assign ar_idx     = s_araddr[IDX_W+1:2];
    assign ar_oor     = addr_oor(64'(s_araddr), IDX_W);

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (commit && !commit_drop) begin
            pulse_d[commit_idx] = 1'b1;
            for (int b = 0; b < BYTES; b++)
                if (commit_strb[b]) regs_d[commit_idx][8*b +: 8] = commit_data[8*b +: 8];
        end
    end

    // Read data comes from regs_q, so a write committing in the AR cycle is not seen.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: if (ar_hs) begin
                rd_state_d = R_DATA;
`ifdef AXIL_REGFILE_SLVERR_EN
                rdata_d    = ar_oor ? '0 : regs_q[ar_idx];
                rresp_d    = ar_oor ? RESP_SLVERR : RESP_OKAY;
`else
                rdata_d    = regs_q[ar_idx];
                rresp_d    = RESP_OKAY;
`endif
            end
            R_DATA: if (s_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

`ifndef AXIL_REGFILE_SLVERR_EN
    logic unused_ar_oor;
    assign unused_ar_oor = ar_oor;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            regs_q     <= '0;
            pulse_q    <= '0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            regs_q     <= regs_d;
            pulse_q    <= pulse_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench with a response scoreboard for axil_slave_regfile.
module tb_axil_slave_regfile;
    import axil_regfile_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic            aclk = 1'b0;
    logic            areset;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic            s_awvalid, s_awready, s_wvalid, s_wready;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]   wr_pulse_o;

    always #5 aclk = ~aclk;

    axil_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    typedef struct packed {logic [31:0] data; logic [1:0] resp;} rexp_t;

    int          vec  = 0;
    int          errs = 0;
    logic [31:0] mregs [NR];
    logic [NR-1:0] exp_pulse;
    logic [1:0]  bq [$];
    rexp_t       rq [$];
    rexp_t       r_hold;
    logic [1:0]  b_hold;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [NR*DW-1:0] e;
        for (int k = 0; k < NR; k++) e[k*32 +: 32] = mregs[k];
        vec++;
        assert (regs_o === e) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, regs_o, e);
        end
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return (a >> ($clog2(NR) + 2)) != 32'd0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[5:2]);
        exp_pulse = '0;
`ifdef AXIL_REGFILE_SLVERR_EN
        if (is_oor(a)) begin
            bq.push_back(RESP_SLVERR);
            return;
        end
`endif
        bq.push_back(RESP_OKAY);
        exp_pulse[idx] = 1'b1;
        for (int b = 0; b < 4; b++)
            if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_rd(input logic [31:0] a);
        rexp_t e;
        e.data = mregs[int'(a[5:2])];
        e.resp = RESP_OKAY;
`ifdef AXIL_REGFILE_SLVERR_EN
        if (is_oor(a)) begin
            e.data = '0;
            e.resp = RESP_SLVERR;
        end
`endif
        rq.push_back(e);
    endtask

    task automatic check_b();
        b_hold = bq.pop_front();
        chk("bvalid", s_bvalid, 1);
        chk("bresp", s_bresp, b_hold);
        chk("wr_pulse", wr_pulse_o, exp_pulse);
        chk_regs("regs_after_wr");
    endtask

    task automatic check_r();
        r_hold = rq.pop_front();
        chk("rvalid", s_rvalid, 1);
        chk("rdata", s_rdata, r_hold.data);
        chk("rresp", s_rresp, r_hold.resp);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        #1;
        chk("awready", s_awready, 1);
        chk("wready", s_wready, 1);
        model_wr(a, d, s);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check_b();
        tick();
        chk("bvalid_clr", s_bvalid, 0);
        chk("pulse_clr", wr_pulse_o, 0);
    endtask

    task automatic axi_read(input logic [31:0] a);
        s_araddr = a; s_arvalid = 1; s_rready = 1;
        #1;
        chk("arready", s_arready, 1);
        model_rd(a);
        tick();
        s_arvalid = 0;
        check_r();
        tick();
        chk("rvalid_clr", s_rvalid, 0);
    endtask

    initial begin
        areset = 1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        exp_pulse = '0;
        for (int k = 0; k < NR; k++) mregs[k] = '0;

        tick(); tick();
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_pulse", wr_pulse_o, 0);
        chk_regs("rst_regs");
        areset = 0;
        #1;
        chk("post_rst_awready", s_awready, 1);
        chk("post_rst_wready", s_wready, 1);
        chk("post_rst_arready", s_arready, 1);

        // single write then read
        axi_write(32'h8, 32'hDEADBEEF, 4'hF);
        chk("t1_reg2", regs_o[2*32 +: 32], 32'hDEADBEEF);
        axi_read(32'h8);

        // W three cycles ahead of AW
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 1;
        tick();
        s_wvalid = 0;
        chk("split_wready0", s_wready, 0);
        chk("split_awready", s_awready, 1);
        chk("split_bvalid0", s_bvalid, 0);
        tick();
        chk("split_wready1", s_wready, 0);
        tick();
        chk("split_wready2", s_wready, 0);
        chk("split_reg1_old", regs_o[1*32 +: 32], 32'h0);
        s_awaddr = 32'h4; s_awvalid = 1;
        model_wr(32'h4, 32'h12345678, 4'hF);
        tick();
        s_awvalid = 0;
        check_b();
        chk("split_reg1", regs_o[1*32 +: 32], 32'h12345678);
        tick();
        chk("split_done", s_bvalid, 0);

        // AR coincides with the final write handshake on the same register
        s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        s_awaddr = 32'hC; s_awvalid = 1;
        s_araddr = 32'hC; s_arvalid = 1; s_rready = 1;
        model_rd(32'hC);
        model_wr(32'hC, 32'h55, 4'hF);
        tick();
        s_awvalid = 0; s_arvalid = 0;
        check_r();
        chk("hazard_old", s_rdata, 32'h0);
        check_b();
        tick();
        chk("hazard_b_clr", s_bvalid, 0);
        chk("hazard_r_clr", s_rvalid, 0);
        axi_read(32'hC);

        // byte strobes
        axi_write(32'hC, 32'hAABBCCDD, 4'hF);
        axi_write(32'hC, 32'h11223344, 4'h5);
        chk("strb_reg3", regs_o[3*32 +: 32], 32'hAA22CC44);

        // backpressure on both response channels
        s_awaddr = 32'h10; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1; s_bready = 0;
        s_araddr = 32'h8; s_arvalid = 1; s_rready = 0;
        model_wr(32'h10, 32'h0BADF00D, 4'hF);
        model_rd(32'h8);
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        check_b();
        check_r();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bvalid", s_bvalid, 1);
            chk("bp_bresp", s_bresp, b_hold);
            chk("bp_rvalid", s_rvalid, 1);
            chk("bp_rdata", s_rdata, r_hold.data);
            chk("bp_awready", s_awready, 0);
            chk("bp_wready", s_wready, 0);
            chk("bp_arready", s_arready, 0);
            chk("bp_pulse", wr_pulse_o, 0);
        end
        s_bready = 1; s_rready = 1;
        tick();
        chk("bp_b_done", s_bvalid, 0);
        chk("bp_r_done", s_rvalid, 0);
        chk("bp_awready_back", s_awready, 1);
        chk("bp_arready_back", s_arready, 1);
        chk_regs("bp_regs");

        // out of range address
        axi_write(32'h40, 32'hCAFEF00D, 4'hF);
`ifdef AXIL_REGFILE_SLVERR_EN
        chk("oor_reg0", regs_o[31:0], 32'h0);
`else
        chk("oor_reg0", regs_o[31:0], 32'hCAFEF00D);
`endif
        axi_read(32'h40);

        // reset while a write response is pending
        s_awaddr = 32'h14; s_wdata = 32'h77778888; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1; s_bready = 0;
        model_wr(32'h14, 32'h77778888, 4'hF);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check_b();
        #2 areset = 1;
        #1;
        chk("mid_rst_bvalid", s_bvalid, 0);
        chk("mid_rst_regs", regs_o == '0, 1);
        chk("mid_rst_pulse", wr_pulse_o, 0);
        chk("mid_rst_awready", s_awready, 0);
        chk("mid_rst_arready", s_arready, 0);
        for (int k = 0; k < NR; k++) mregs[k] = '0;
        bq.delete();
        rq.delete();
        tick();
        areset = 0;
        s_bready = 1;
        #1;
        chk("rel_awready", s_awready, 1);
        chk("rel_bvalid", s_bvalid, 0);
        axi_read(32'h8);
        axi_write(32'h3C, 32'h600DCAFE, 4'hF);
        axi_read(32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
